// File: rtl/vga_sprite_pkg.sv
// vga_sprite_pkg: shared sprite descriptor type and screen/sheet constants
package vga_sprite_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SHEET_W = 320;
  localparam int SPR_COORD_W = 10;
  localparam int SPR_ADDR_W = 17;
  typedef struct packed {
    logic [SPR_COORD_W-1:0] x;
    logic [SPR_COORD_W-1:0] y;
    logic [6:0]             w;
    logic [6:0]             h;
    logic [SPR_ADDR_W-1:0]  base;
    logic                   en;
    logic                   blink;
  } spr_desc_t;
endpackage

// File: rtl/vga_sprite_hit.sv
// vga_sprite_hit: box test and sheet address of one 2x-scaled sprite
module vga_sprite_hit #(
  parameter int COORD_W = 10,
  parameter int ADDR_W = 17,
  parameter int SHEET_W = 320
) (
  input  vga_sprite_pkg::spr_desc_t desc,
  input  logic [COORD_W-1:0]        x,
  input  logic [COORD_W-1:0]        y,
  output logic                      box,
  output logic [ADDR_W-1:0]         addr
);
  logic [COORD_W:0] x_end, y_end;
  logic [COORD_W-1:0] dx, dy;
  // one extra bit keeps the right/bottom edges from wrapping; zero size yields an empty box
  always_comb begin
    x_end = {1'b0, desc.x} + (COORD_W+1)'({desc.w, 1'b0});
    y_end = {1'b0, desc.y} + (COORD_W+1)'({desc.h, 1'b0});
    box = x >= desc.x && {1'b0, x} < x_end && y >= desc.y && {1'b0, y} < y_end;
    dx = x - desc.x;
    dy = y - desc.y;
    addr = desc.base + ADDR_W'(dy >> 1) * ADDR_W'(SHEET_W) + ADDR_W'(dx >> 1);
  end
endmodule

// File: rtl/vga_sprite_compositor.sv
// vga_sprite_compositor: double-buffered sprite table, 2-stage pixel resolve, blink and collision
module vga_sprite_compositor #(
  parameter int NUM_SPR = 8,
  parameter int COORD_W = 10,
  parameter int ADDR_W = 17,
  parameter int SHEET_W = 320,
  parameter int BG_ADDR = 9290,
  parameter int BLINK_FRAMES = 8,
  localparam int IDX_W = NUM_SPR > 1 ? $clog2(NUM_SPR) : 1,
  localparam int FC_W = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1
) (
  input  logic               clk_vga,
  input  logic               rst_n,
  input  logic               valid,
  input  logic [COORD_W-1:0] xpos,
  input  logic [COORD_W-1:0] ypos,
  input  logic               frame_start,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [COORD_W-1:0] cfg_x,
  input  logic [COORD_W-1:0] cfg_y,
  input  logic [6:0]         cfg_w,
  input  logic [6:0]         cfg_h,
  input  logic [ADDR_W-1:0]  cfg_base,
  input  logic               cfg_en,
  input  logic               cfg_blink,
  output logic [ADDR_W-1:0]  pixel_addr,
  output logic               pixel_valid,
  output logic               hit,
  output logic [IDX_W-1:0]   hit_idx,
  output logic               collide_frame,
  output logic [NUM_SPR-1:0] collide_mask
);
  import vga_sprite_pkg::*;
  spr_desc_t shadow_q [NUM_SPR], shadow_d [NUM_SPR];
  spr_desc_t active_q [NUM_SPR], active_d [NUM_SPR];
  spr_desc_t wdesc;
  logic [FC_W-1:0] fcnt_q, fcnt_d;
  logic phase_q, phase_d, wrap;
  logic [NUM_SPR-1:0] box, h1_q, h1_d;
  logic [ADDR_W-1:0] addr [NUM_SPR];
  logic [ADDR_W-1:0] a1_q [NUM_SPR];
  logic v1_q;
  logic [IDX_W-1:0] win;
  logic coll, coll_acc_q, coll_acc_d;
  logic [NUM_SPR-1:0] mask_acc_q, mask_acc_d;
  logic [ADDR_W-1:0] pixel_addr_q, pixel_addr_d;
  logic hit_q, hit_d, collide_frame_q, collide_frame_d;
  logic [IDX_W-1:0] hit_idx_q, hit_idx_d;
  logic [NUM_SPR-1:0] collide_mask_q, collide_mask_d;

  assign wdesc = '{cfg_x, cfg_y, cfg_w, cfg_h, cfg_base, cfg_en, cfg_blink};

  for (genvar g = 0; g < NUM_SPR; g++) begin : g_spr
    vga_sprite_hit #(.COORD_W(COORD_W), .ADDR_W(ADDR_W), .SHEET_W(SHEET_W)) u_hit (
      .desc(active_q[g]), .x(xpos), .y(ypos), .box(box[g]), .addr(addr[g])
    );
    assign h1_d[g] = valid && box[g] && active_q[g].en && !(active_q[g].blink && phase_q);
  end

  // shadow write, frame-start commit (same-cycle write forwarded through shadow_d) and blink counter
  always_comb begin
    shadow_d = shadow_q;
    if (cfg_we) shadow_d[cfg_idx] = wdesc;
    active_d = frame_start ? shadow_d : active_q;
    wrap = fcnt_q == FC_W'(BLINK_FRAMES - 1);
    fcnt_d = !frame_start ? fcnt_q : wrap ? '0 : fcnt_q + 1'b1;
    phase_d = phase_q ^ (frame_start && wrap);
  end

  // stage 2: lowest hitting index wins; collision counts stage-1 pixels, including the one at frame_start
  always_comb begin
    win = '0;
    for (int i = NUM_SPR - 1; i >= 0; i--) if (h1_q[i]) win = IDX_W'(i);
    hit_d = |h1_q;
    hit_idx_d = win;
    pixel_addr_d = !v1_q ? '0 : hit_d ? a1_q[win] : ADDR_W'(BG_ADDR);
    coll = (h1_q & (h1_q - NUM_SPR'(1))) != '0;
    coll_acc_d = frame_start ? 1'b0 : coll_acc_q | coll;
    mask_acc_d = frame_start ? '0 : mask_acc_q | (coll ? h1_q : '0);
    collide_frame_d = frame_start ? coll_acc_q | coll : collide_frame_q;
    collide_mask_d = frame_start ? mask_acc_q | (coll ? h1_q : '0) : collide_mask_q;
  end

  // all state registers; reset clears tables, blink state, accumulators and outputs
  always_ff @(posedge clk_vga or negedge rst_n)
    if (!rst_n) begin
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
      fcnt_q <= '0;
      phase_q <= 1'b0;
      v1_q <= 1'b0;
      h1_q <= '0;
      a1_q <= '{default: '0};
      coll_acc_q <= 1'b0;
      mask_acc_q <= '0;
      pixel_addr_q <= '0;
      pixel_valid <= 1'b0;
      hit_q <= 1'b0;
      hit_idx_q <= '0;
      collide_frame_q <= 1'b0;
      collide_mask_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      fcnt_q <= fcnt_d;
      phase_q <= phase_d;
      v1_q <= valid;
      h1_q <= h1_d;
      a1_q <= addr;
      coll_acc_q <= coll_acc_d;
      mask_acc_q <= mask_acc_d;
      pixel_addr_q <= pixel_addr_d;
      pixel_valid <= v1_q;
      hit_q <= hit_d;
      hit_idx_q <= hit_idx_d;
      collide_frame_q <= collide_frame_d;
      collide_mask_q <= collide_mask_d;
    end

  assign pixel_addr = pixel_addr_q;
  assign hit = hit_q;
  assign hit_idx = hit_idx_q;
  assign collide_frame = collide_frame_q;
  assign collide_mask = collide_mask_q;
endmodule

// File: tb/tb_vga_sprite_compositor.sv
// tb_vga_sprite_compositor: directed checks of the sprite compositor with hand-computed values
module tb_vga_sprite_compositor;
  logic clk_vga = 0, rst_n = 0, valid = 0, frame_start = 0, cfg_we = 0, cfg_en = 0, cfg_blink = 0;
  logic [9:0] xpos = 0, ypos = 0, cfg_x = 0, cfg_y = 0;
  logic [2:0] cfg_idx = 0;
  logic [6:0] cfg_w = 0, cfg_h = 0;
  logic [16:0] cfg_base = 0;
  logic [16:0] pixel_addr;
  logic pixel_valid, hit, collide_frame;
  logic [2:0] hit_idx;
  logic [7:0] collide_mask;
  int n_cmp = 0, n_bad = 0;
  localparam int BG = 9290;

  vga_sprite_compositor #(.BLINK_FRAMES(2)) dut (
    .clk_vga(clk_vga), .rst_n(rst_n), .valid(valid), .xpos(xpos), .ypos(ypos),
    .frame_start(frame_start), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y),
    .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_base(cfg_base), .cfg_en(cfg_en), .cfg_blink(cfg_blink),
    .pixel_addr(pixel_addr), .pixel_valid(pixel_valid), .hit(hit), .hit_idx(hit_idx),
    .collide_frame(collide_frame), .collide_mask(collide_mask)
  );

  always #5 clk_vga = ~clk_vga;

  task automatic tick;
    @(posedge clk_vga);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wr(input int idx, input int x, input int y, input int w, input int h,
                    input int base, input logic en, input logic blink);
    cfg_we = 1; cfg_idx = 3'(idx); cfg_x = 10'(x); cfg_y = 10'(y);
    cfg_w = 7'(w); cfg_h = 7'(h); cfg_base = 17'(base); cfg_en = en; cfg_blink = blink;
    tick;
    cfg_we = 0;
  endtask

  task automatic frame;
    frame_start = 1;
    tick;
    frame_start = 0;
  endtask

  task automatic expect_px(input string tag, input int addr, input logic h, input int idx);
    chk({tag, ".valid"}, 32'(pixel_valid), 1);
    chk({tag, ".addr"}, 32'(pixel_addr), addr);
    chk({tag, ".hit"}, 32'(hit), 32'(h));
    if (h) chk({tag, ".idx"}, 32'(hit_idx), idx);
  endtask

  task automatic probe(input string tag, input int x, input int y, input int addr,
                       input logic h, input int idx);
    valid = 1; xpos = 10'(x); ypos = 10'(y);
    tick;
    valid = 0;
    tick;
    expect_px(tag, addr, h, idx);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".addr"}, 32'(pixel_addr), 0);
    chk({tag, ".pvalid"}, 32'(pixel_valid), 0);
    chk({tag, ".hit"}, 32'(hit), 0);
    chk({tag, ".idx"}, 32'(hit_idx), 0);
    chk({tag, ".cf"}, 32'(collide_frame), 0);
    chk({tag, ".cm"}, 32'(collide_mask), 0);
  endtask

  initial begin
    #3;
    chk_zero("reset");
    #4 rst_n = 1;
    tick;
    probe("bg", 0, 0, BG, 0, 0);
    tick;
    chk("idle.pvalid", 32'(pixel_valid), 0);
    chk("idle.addr", 32'(pixel_addr), 0);

    wr(3, 100, 200, 60, 56, 8065, 1, 0);
    probe("precommit", 101, 203, BG, 0, 0);
    frame();
    probe("s3.a", 101, 203, 8385, 1, 3);
    probe("s3.xend", 220, 203, BG, 0, 0);
    probe("s3.xlast", 219, 203, 8444, 1, 3);
    probe("s3.ylast", 101, 311, 25665, 1, 3);
    probe("s3.yend", 101, 312, BG, 0, 0);
    probe("s3.xlo", 99, 203, BG, 0, 0);

    wr(3, 100, 200, 60, 56, 8065, 0, 0);
    wr(1, 140, 240, 10, 10, 1000, 1, 0);
    wr(5, 145, 245, 10, 10, 2000, 1, 0);
    wr(6, 0, 0, 0, 10, 3000, 1, 0);
    frame();
    chk("coll0.cf", 32'(collide_frame), 0);
    probe("zero_w", 0, 0, BG, 0, 0);
    valid = 1; xpos = 150; ypos = 250;
    tick;
    valid = 0; frame_start = 1;
    tick;
    frame_start = 0;
    expect_px("prio", 2605, 1, 1);
    chk("coll.cf", 32'(collide_frame), 1);
    chk("coll.cm", 32'(collide_mask), 32'h22);
    wr(5, 145, 245, 10, 10, 2000, 0, 0);
    frame();
    chk("nocoll.cf", 32'(collide_frame), 0);
    chk("nocoll.cm", 32'(collide_mask), 0);

    wr(0, 10, 10, 4, 4, 500, 1, 0);
    frame();
    probe("db.old", 10, 10, 500, 1, 0);
    wr(0, 300, 10, 4, 4, 500, 1, 0);
    probe("db.keep", 10, 10, 500, 1, 0);
    probe("db.notyet", 300, 10, BG, 0, 0);
    frame();
    probe("db.new", 300, 10, 500, 1, 0);
    probe("db.gone", 10, 10, BG, 0, 0);
    cfg_we = 1; cfg_idx = 0; cfg_x = 400; cfg_y = 10; cfg_w = 4; cfg_h = 4;
    cfg_base = 500; cfg_en = 1; cfg_blink = 0; frame_start = 1;
    tick;
    cfg_we = 0; frame_start = 0;
    probe("db.fwd", 400, 10, 500, 1, 0);

    wr(0, 20, 10, 4, 4, 500, 1, 0);
    valid = 1; xpos = 400; ypos = 10; frame_start = 1;
    tick;
    frame_start = 0; xpos = 20;
    tick;
    valid = 0;
    expect_px("align.old", 500, 1, 0);
    tick;
    expect_px("align.new", 500, 1, 0);

    valid = 1; xpos = 20; ypos = 10;
    tick;
    tick;
    chk("midrst.pre", 32'(hit), 1);
    #2 rst_n = 0;
    #1;
    chk_zero("midrst");
    valid = 0;
    #2 rst_n = 1;
    tick;
    probe("midrst.empty", 20, 10, BG, 0, 0);

    wr(2, 50, 50, 4, 4, 700, 1, 1);
    for (int p = 1; p <= 5; p++) begin
      logic vis;
      frame();
      vis = ((p / 2) % 2) == 0;
      probe($sformatf("blink%0d", p), 50, 50, vis ? 700 : BG, vis, 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
